// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: IB entry layout,
// fetch FSM state encoding, exception codes and the entry packing helper.
package if_fetch_unit_pkg;

    localparam int IB_W        = 71;
    localparam int EXC_FIELD_W = 6;
    localparam int IB_VLD_BIT  = 0;
    localparam int IB_INSN_LSB = 1;
    localparam int IB_PC_LSB   = 33;
    localparam int IB_EXC_LSB  = 65;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_e;

    localparam logic [EXC_FIELD_W-1:0] EXC_NONE            = 6'h00;
    localparam logic [EXC_FIELD_W-1:0] EXC_IFETCH_ERR      = 6'h01;
    localparam logic [EXC_FIELD_W-1:0] EXC_IFETCH_MISALIGN = 6'h02;

    function automatic logic [IB_W-1:0] pack_entry(
        input logic [EXC_FIELD_W-1:0] exc,
        input logic [31:0]            pc,
        input logic [31:0]            insn
    );
        logic [IB_W-1:0] e;
        e                              = '0;
        e[IB_EXC_LSB +: EXC_FIELD_W]   = exc;
        e[IB_PC_LSB +: 32]             = pc;
        e[IB_INSN_LSB +: 32]           = insn;
        e[IB_VLD_BIT]                  = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register that parks a fetched IB entry while the IB
// is full. Clear wins over load so a flush never resurrects an entry.
module if_hold_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int W = IB_W
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] data
);

    // Entry storage with valid flag
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IB FIFO: single-outstanding imem
// requests, IB back-pressure, stall and flush/redirect. Optional feature
// macro: IF_MISALIGN_CHECK_EN (misaligned PC raises a fetch fault entry).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          EXC_W        = 6
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_err,
    input  logic               ib_full,
    output logic               ib_w_en,
    output logic [EXC_W+64:0]  ib_data
);

    fetch_state_e    state_r;
    logic [31:0]     pc_r;
    logic [31:0]     pc_inc_s;
    logic            misalign_s;
    logic            gnt_s;
    logic [IB_W-1:0] resp_entry_s;
    logic            hold_load_s;
    logic            hold_clear_s;
    logic            hold_valid_s;
    logic [IB_W-1:0] hold_data_s;
    logic            hold_err_s;

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign_s = (pc_r[1:0] != 2'b00);
    assign imem_addr  = pc_r;
`else
    assign misalign_s = 1'b0;
    assign imem_addr  = {pc_r[31:2], 2'b00};
`endif

    assign imem_req     = (state_r == ST_REQ) && !misalign_s;
    assign gnt_s        = imem_req && imem_gnt;
    assign pc_inc_s     = pc_r + 32'd4;
    assign resp_entry_s = imem_err ? pack_entry(EXC_IFETCH_ERR, pc_r, 32'h0000_0000)
                                   : pack_entry(EXC_NONE, pc_r, imem_rdata);
    assign hold_err_s   = (hold_data_s[IB_EXC_LSB +: EXC_FIELD_W] != EXC_NONE);
    assign hold_clear_s = flush || ((state_r == ST_HOLD) && !ib_full);

    if_hold_buf #(.W(IB_W)) u_hold_buf (
        .clk   (clk),
        .rst_  (rst_),
        .load  (hold_load_s),
        .clear (hold_clear_s),
        .din   (resp_entry_s),
        .valid (hold_valid_s),
        .data  (hold_data_s)
    );

    // IB write port: fresh response, replay of the held entry, or misalign fault entry
    always_comb begin
        ib_w_en     = 1'b0;
        ib_data     = '0;
        hold_load_s = 1'b0;
        if (flush) begin
            ib_w_en = 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (imem_rvalid && !ib_full) begin
                        ib_w_en = 1'b1;
                        ib_data = resp_entry_s;
                    end else if (imem_rvalid) begin
                        hold_load_s = 1'b1;
                    end else begin
                        hold_load_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_valid_s && !ib_full) begin
                        ib_w_en = 1'b1;
                        ib_data = hold_data_s;
                    end else begin
                        ib_w_en = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (misalign_s && !ib_full) begin
                        ib_w_en = 1'b1;
                        ib_data = pack_entry(EXC_IFETCH_MISALIGN, pc_r, 32'h0000_0000);
                    end else begin
                        ib_w_en = 1'b0;
                    end
                end
                default: ib_w_en = 1'b0;
            endcase
        end
    end

    // Fetch FSM and PC; flush overrides every other transition
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_VECTOR;
        end else if (flush) begin
            pc_r <= redirect_pc;
            case (state_r)
                ST_WAIT:  state_r <= imem_rvalid ? ST_REQ : ST_DROP;
                ST_REQ:   state_r <= gnt_s ? ST_DROP : ST_REQ;
                // An old response is still owed; keep waiting so only one stays outstanding
                ST_DROP:  state_r <= imem_rvalid ? ST_REQ : ST_DROP;
                default:  state_r <= ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!stall && !ib_full) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (misalign_s) begin
                        if (!ib_full) begin
                            state_r <= ST_FAULT;
                        end
                    end else if (gnt_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (ib_full) begin
                            state_r <= ST_HOLD;
                        end else if (imem_err) begin
                            state_r <= ST_FAULT;
                        end else begin
                            pc_r    <= pc_inc_s;
                            state_r <= stall ? ST_IDLE : ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!ib_full) begin
                        if (hold_err_s) begin
                            state_r <= ST_FAULT;
                        end else begin
                            pc_r    <= pc_inc_s;
                            state_r <= stall ? ST_IDLE : ST_REQ;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_FAULT: state_r <= ST_FAULT;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: transaction-level memory responder and an
// in-order PC/entry scoreboard. Honours IF_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk         = 1'b0;
    logic        rst_        = 1'b1;
    logic        stall       = 1'b0;
    logic        flush       = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        imem_err    = 1'b0;
    logic        ib_full     = 1'b0;
    logic        ib_w_en;
    logic [70:0] ib_data;

    if_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .EXC_W(6)) dut (
        .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .ib_full(ib_full), .ib_w_en(ib_w_en), .ib_data(ib_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int gnt_pct = 100, full_pct = 0, stall_pct = 0, flush_pct = 0, lat_lo = 0, lat_hi = 0;
    int full_force = 0, mem_lat = 0, writes = 0;
    logic        mem_busy = 1'b0, in_fault = 1'b0, err_arm = 1'b0, gnt_seen = 1'b0;
    logic [31:0] mem_addr = 32'h0, exp_pc = 32'h0, err_addr = 32'h0, last_gnt_addr = 32'h0;

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [70:0] exp_entry(input logic [5:0] exc, input logic [31:0] pc);
        logic [31:0] insn;
        insn = (exc == 6'h00) ? insn_of({pc[31:2], 2'b00}) : 32'h0;
        return {exc, pc, insn, 1'b1};
    endfunction

    task automatic apply_reset();
        rst_ = 1'b1; #1; rst_ = 1'b0;
        flush = 1'b0; stall = 1'b0; ib_full = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
        mem_busy = 1'b0; in_fault = 1'b0; exp_pc = 32'h0; err_arm = 1'b0; full_force = 0;
        lat_lo = 0; lat_hi = 0; gnt_pct = 100; full_pct = 0; stall_pct = 0; flush_pct = 0;
        #1;
        check_val("reset_req", imem_req, 1'b0);
        check_val("reset_wen", ib_w_en, 1'b0);
        check_val("reset_data", ib_data, 71'h0);
        check_val("reset_addr", imem_addr, 32'h0);
        @(posedge clk); #1; rst_ = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+3, then advance the model.
    task automatic cycle(input logic do_flush, input logic [31:0] rpc);
        logic [5:0] exc;
        logic       gnt_now;
        flush = do_flush; redirect_pc = rpc;
        stall   = ($urandom_range(99) < stall_pct);
        ib_full = (full_force > 0) || ($urandom_range(99) < full_pct);
        if (full_force > 0) full_force--;
        gnt_now  = imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
        imem_gnt = gnt_now;
        if (mem_busy && mem_lat == 0) begin
            imem_rvalid = 1'b1; imem_rdata = insn_of(mem_addr);
            imem_err    = err_arm && (mem_addr == err_addr);
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom; imem_err = ($urandom_range(1) == 1);
        end
        #2;
        if (imem_req) check_val("one_outstanding", mem_busy, 1'b0);
        if (in_fault) check_val("fault_no_req", imem_req, 1'b0);
`ifdef IF_MISALIGN_CHECK_EN
        if (exp_pc[1:0] != 2'b00) check_val("misalign_no_req", imem_req, 1'b0);
`endif
        if (ib_full || do_flush || in_fault) begin
            check_val("w_en_blocked", ib_w_en, 1'b0);
        end else if (ib_w_en) begin
            exc = 6'h00;
            if (err_arm && exp_pc == err_addr) exc = 6'h01;
`ifdef IF_MISALIGN_CHECK_EN
            if (exp_pc[1:0] != 2'b00) exc = 6'h02;
`endif
            check_val("ib_entry", ib_data, exp_entry(exc, exp_pc));
            writes++;
            if (exc != 6'h00) in_fault = 1'b1;
            else exp_pc = exp_pc + 32'd4;
        end
        if (gnt_now) begin
            gnt_seen = 1'b1; last_gnt_addr = imem_addr;
            if (!do_flush) check_val("req_addr", imem_addr, {exp_pc[31:2], 2'b00});
        end
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (gnt_now) begin
            mem_busy = 1'b1; mem_addr = imem_addr; mem_lat = $urandom_range(lat_hi, lat_lo);
        end
        if (do_flush) begin exp_pc = rpc; in_fault = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic rcycle();
        logic [31:0] r;
        r = $urandom; r[1:0] = 2'b00;
        cycle($urandom_range(99) < flush_pct, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w0;
        logic ok;
        // Back-to-back fetch from reset: one entry every second cycle
        apply_reset();
        w0 = writes;
        repeat (8) cycle(1'b0, 32'h0);
        check_val("t1_throughput", writes - w0, 3);

        // IB full on the response cycle and two more: exactly one write afterwards
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_busy && mem_lat == 0) begin ok = 1'b1; break; end
            cycle(1'b0, 32'h0);
        end
        check_val("t2_reach_wait", ok, 1'b1);
        w0 = writes; full_force = 3;
        repeat (3) cycle(1'b0, 32'h0);
        check_val("t2_held_while_full", writes - w0, 0);
        cycle(1'b0, 32'h0);
        check_val("t2_hold_written", writes - w0, 1);
        repeat (4) cycle(1'b0, 32'h0);

        // Flush in WAIT, stale response arrives two cycles later and is dropped
        lat_lo = 2; lat_hi = 2; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (mem_busy && mem_lat == 2) begin ok = 1'b1; break; end
        end
        check_val("t3_reach_wait", ok, 1'b1);
        cycle(1'b1, 32'h100);
        lat_lo = 0; lat_hi = 0; gnt_seen = 1'b0; w0 = writes;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (gnt_seen) break;
        end
        check_val("t3_redirect_addr", last_gnt_addr, 32'h100);
        repeat (4) cycle(1'b0, 32'h0);
        check_val("t3_refill", writes - w0 >= 1, 1'b1);

        // Bus error at 0x20: fault entry, then silence until flush
        apply_reset();
        err_arm = 1'b1; err_addr = 32'h20; ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b0, 32'h0);
            if (in_fault) begin ok = 1'b1; break; end
        end
        check_val("t4_fault_entry", ok, 1'b1);
        repeat (8) cycle(1'b0, 32'h0);
        err_arm = 1'b0;

        // Redirect to a misaligned PC
        cycle(1'b1, 32'h102);
        gnt_seen = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (in_fault) begin ok = 1'b1; break; end
        end
        check_val("t5_misalign_fault", ok, 1'b1);
        repeat (4) cycle(1'b0, 32'h0);
        check_val("t5_no_req", gnt_seen, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (gnt_seen) break;
        end
        check_val("t5_aligned_addr", last_gnt_addr, 32'h100);
        repeat (6) cycle(1'b0, 32'h0);
`endif

        // Stall holds IDLE; then reset in the middle of WAIT
        cycle(1'b1, 32'h200);
        stall_pct = 100;
        repeat (6) cycle(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0);
            check_val("t6_stall_idle", imem_req, 1'b0);
        end
        stall_pct = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (mem_busy) begin ok = 1'b1; break; end
        end
        check_val("t6_reach_wait", ok, 1'b1);
        rst_ = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_err = 1'b0; ib_full = 1'b0;
        #1;
        check_val("t6_rst_req", imem_req, 1'b0);
        check_val("t6_rst_wen", ib_w_en, 1'b0);
        check_val("t6_rst_data", ib_data, 71'h0);
        check_val("t6_rst_addr", imem_addr, 32'h0);
        apply_reset();
        gnt_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            if (gnt_seen) break;
        end
        check_val("t6_restart_addr", last_gnt_addr, 32'h0);

        // Randomised traffic with flushes, stalls, back-pressure and a PC wrap
        gnt_pct = 60; full_pct = 30; stall_pct = 20; flush_pct = 3; lat_lo = 0; lat_hi = 3;
        w0 = writes;
        for (int i = 0; i < 700; i++) rcycle();
        check_val("rand_progress_a", writes - w0 > 40, 1'b1);
        flush_pct = 0;
        cycle(1'b1, 32'hFFFF_FFF0);
        w0 = writes;
        for (int i = 0; i < 120; i++) rcycle();
        check_val("wrap_progress", writes - w0 >= 6, 1'b1);
        flush_pct = 3; w0 = writes;
        for (int i = 0; i < 700; i++) rcycle();
        check_val("rand_progress_b", writes - w0 > 40, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
